// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the core's load/store interface. It holds one request at a
//   time and, after a fixed latency, performs a byte, half or word access on an
//   internal word array. It returns the load data (sign- or zero-extended), or a
//   write acknowledge, together with an error flag.
//
// Ports
//   clk           clock; all state updates happen on the rising edge
//   reset         synchronous active-high reset
//   req_valid     request presented by the core
//   req_ready     responder can accept a request this cycle
//   req_write     1 = store, 0 = load
//   req_addr      byte address; word index = req_addr[31:2]
//   req_wdata     store data, right-aligned
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 zero-extend, 0 sign-extend
//   rsp_valid     response available
//   rsp_ready     core consumes the response
//   rsp_rdata     load result; 0 for stores and errors
//   rsp_error     misaligned access, illegal size or out-of-range address
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned LATENCY     = 2      // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           wr_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [1:0]     size_q;
    logic           uns_q;

    logic           req_ready_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_rdata_q;
    logic           rsp_error_q;

    // Word storage; deliberately not cleared by reset.
    logic [31:0]    memory [DEPTH_WORDS];

    logic           err_c;
    logic [AW-1:0]  widx_c;
    logic [31:0]    rd_word_c;
    logic [31:0]    store_word_c;
    logic [31:0]    load_c;
    logic [7:0]     byte_c;
    logic [15:0]    half_c;
    logic           access_c;
    logic           mem_we_c;

    // Error classification of the latched request.
    always_comb begin
        err_c = 1'b0;
        if (size_q == 2'b11)                        err_c = 1'b1;
        if (size_q == 2'b01 && addr_q[0])           err_c = 1'b1;
        if (size_q == 2'b10 && addr_q[1:0] != 2'b00) err_c = 1'b1;
        if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) err_c = 1'b1;
    end

    assign widx_c    = addr_q[AW+1:2];
    assign rd_word_c = memory[widx_c];

    // Merge right-aligned store data into the addressed lanes only.
    always_comb begin
        store_word_c = rd_word_c;
        case (size_q)
            2'b00:   store_word_c[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) store_word_c[31:16] = wdata_q[15:0];
                else           store_word_c[15:0]  = wdata_q[15:0];
            end
            2'b10:   store_word_c = wdata_q;
            default: store_word_c = rd_word_c;
        endcase
    end

    // Lane extraction and extension for loads.
    always_comb begin
        byte_c = rd_word_c[{addr_q[1:0], 3'b000} +: 8];
        half_c = addr_q[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        load_c = 32'h0;
        case (size_q)
            2'b00:   load_c = {{24{~uns_q & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{~uns_q & half_c[15]}}, half_c};
            2'b10:   load_c = rd_word_c;
            default: load_c = 32'h0;
        endcase
    end

    // The access happens on the last WAIT cycle; reset in that cycle drops it.
    assign access_c = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we_c = !reset && access_c && wr_q && !err_c;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            memory[widx_c] <= store_word_c;
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        cnt_q       <= CW'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= err_c;
                        rsp_rdata_q <= (err_c || wr_q) ? 32'h0 : load_c;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_error_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. A transaction-level model tracks
//   what each output must be on every cycle and is compared at the falling edge;
//   literal expectations on the returned data pin the model itself.
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 512;
    localparam int unsigned LAT     = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // ------------------------------------------------------------------
    logic [31:0] mem_m [DEPTH];
    int          cyc = 0;
    bit          busy = 0;
    bit          showing = 0;
    int          due = 0;
    logic        m_w, m_u;
    logic [31:0] m_a, m_d;
    logic [1:0]  m_sz;
    logic        exp_req_ready = 1'b1;
    logic        exp_rsp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic        exp_error = 1'b0;

    function automatic void respond(input logic w, input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] sz, input logic u,
                                    output logic [31:0] rd, output logic er);
        int unsigned sh;
        int unsigned idx;
        logic [31:0] word, v, mask;
        er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
             (sz == 2'd2 && (a % 4) != 0) || ((a >> 2) >= DEPTH);
        rd = 32'h0;
        if (er) return;
        idx  = a >> 2;
        word = mem_m[idx];
        sh   = 8 * (a % 4);
        if (w) begin
            if (sz == 2'd0)      mask = 32'h0000_00FF << sh;
            else if (sz == 2'd1) mask = 32'h0000_FFFF << sh;
            else                 mask = 32'hFFFF_FFFF;
            mem_m[idx] = (word & ~mask) | ((d << sh) & mask);
        end else begin
            v = word >> sh;
            if (sz == 2'd0) begin
                v = v & 32'hFF;
                if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = v & 32'hFFFF;
                if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            rd = v;
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy    = 0;
            showing = 0;
            exp_rdata = 32'h0;
            exp_error = 1'b0;
        end else if (!busy) begin
            if (req_valid) begin
                busy = 1;
                due  = cyc + LAT;
                m_w = req_write; m_a = req_addr; m_d = req_wdata;
                m_sz = req_size; m_u = req_unsigned;
            end
        end else if (!showing) begin
            if (cyc == due) begin
                respond(m_w, m_a, m_d, m_sz, m_u, exp_rdata, exp_error);
                showing = 1;
            end
        end else if (rsp_ready) begin
            busy    = 0;
            showing = 0;
            exp_rdata = 32'h0;
            exp_error = 1'b0;
        end
        exp_req_ready = !busy;
        exp_rsp_valid = showing;
        cyc++;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check32("req_ready", 32'(req_ready), 32'(exp_req_ready));
            check32("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            check32("rsp_rdata", rsp_rdata, exp_rdata);
            check32("rsp_error", 32'(rsp_error), 32'(exp_error));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u, input int hold, input bit junk,
                       output logic [31:0] rd, output logic er);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = u;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid never rose for addr 0x%08h", a);
        end
        rd = rsp_rdata;
        er = rsp_error;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
                req_wdata = 32'hFFFF_FFFF; req_size = 2'd2;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    task automatic ld(input string name, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] exp_d, input logic exp_e);
        txn(1'b0, a, 32'h0, sz, u, 0, 0, rd, er);
        check32({name, "_data"}, rd, exp_d);
        check32({name, "_err"}, 32'(er), 32'(exp_e));
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        txn(1'b1, a, d, sz, 1'b0, 0, 0, rd, er);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = '0; req_unsigned = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        started = 1;
        check32("reset_req_ready", 32'(req_ready), 32'h1);
        check32("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check32("reset_rsp_rdata", rsp_rdata, 32'h0);

        // Word store/load
        st(32'h010, 32'hDEAD_BEEF, 2'd2);
        check32("sw_err", 32'(er), 32'h0);
        ld("lw_010", 32'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Byte/half extension
        st(32'h004, 32'h80FF_7F01, 2'd2);
        ld("lb_007",  32'h007, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0);
        ld("lbu_007", 32'h007, 2'd0, 1'b1, 32'h0000_0080, 1'b0);
        ld("lb_004",  32'h004, 2'd0, 1'b0, 32'h0000_0001, 1'b0);
        ld("lh_004",  32'h004, 2'd1, 1'b0, 32'h0000_7F01, 1'b0);
        ld("lhu_006", 32'h006, 2'd1, 1'b1, 32'h0000_80FF, 1'b0);
        ld("lh_006",  32'h006, 2'd1, 1'b0, 32'hFFFF_80FF, 1'b0);
        ld("lw_u_004", 32'h004, 2'd2, 1'b1, 32'h80FF_7F01, 1'b0);

        // Partial store merge
        st(32'h008, 32'h1122_3344, 2'd2);
        st(32'h009, 32'h0000_00AA, 2'd0);
        ld("merge_sb", 32'h008, 2'd2, 1'b0, 32'h1122_AA44, 1'b0);
        st(32'h00A, 32'h0000_BEEF, 2'd1);
        ld("merge_sh", 32'h008, 2'd2, 1'b0, 32'hBEEF_AA44, 1'b0);

        // Errors leave memory untouched
        st(32'h000, 32'h0BAD_F00D, 2'd2);
        ld("err_lw_002",  32'h002, 2'd2, 1'b0, 32'h0, 1'b1);
        ld("err_lh_001",  32'h001, 2'd1, 1'b0, 32'h0, 1'b1);
        ld("err_size3",   32'h010, 2'd3, 1'b0, 32'h0, 1'b1);
        ld("err_lw_800",  32'h800, 2'd2, 1'b0, 32'h0, 1'b1);
        txn(1'b1, 32'h800, 32'h5555_5555, 2'd2, 1'b0, 0, 0, rd, er);
        check32("err_sw_800", 32'(er), 32'h1);
        txn(1'b1, 32'h011, 32'h7777, 2'd1, 1'b0, 0, 0, rd, er);
        check32("err_sh_011", 32'(er), 32'h1);
        ld("unch_000", 32'h000, 2'd2, 1'b0, 32'h0BAD_F00D, 1'b0);
        ld("unch_010", 32'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Backpressure with ignored requests in flight
        txn(1'b0, 32'h010, 32'h0, 2'd2, 1'b0, 5, 1, rd, er);
        check32("bp_data", rd, 32'hDEAD_BEEF);
        check32("bp_req_ready", 32'(req_ready), 32'h1);
        ld("bp_after", 32'h010, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Reset while waiting drops an uncommitted store
        st(32'h020, 32'hCAFE_F00D, 2'd2);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h020;
        req_wdata = 32'h1234_5678; req_size = 2'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check32("rst_req_ready", 32'(req_ready), 32'h1);
        check32("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        ld("rst_lw_020", 32'h020, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
